// File: rtl/csr_timer.sv
// LoongArch CSR timer unit: TID/TCFG/TVAL registers, countdown timer and
// the 64-bit stable counter used by rdcntvl.w / rdcntvh.w / rdcntid.
module csr_timer #(
   parameter int          TIMER_N   = 32,
   parameter logic [31:0] TID_RESET = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        csr_we,
   input  logic [13:0] csr_num,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wvalue,
   input  logic [13:0] csr_rnum,
   output logic [31:0] csr_rvalue,
   output logic        csr_rhit,
   output logic [31:0] timer_cnt,
   output logic [63:0] stable_cnt,
   output logic [31:0] counter_id
);
   localparam logic [13:0] TID_ADDR   = 14'h40;
   localparam logic [13:0] TCFG_ADDR  = 14'h41;
   localparam logic [13:0] TVAL_ADDR  = 14'h42;
   // bits at and above TIMER_N are forced to 0, so they never hold state
   localparam logic [31:0] TCFG_MASK  = (TIMER_N >= 32) ? 32'hFFFF_FFFF
                                        : 32'((64'd1 << TIMER_N) - 64'd1);
   localparam logic [31:0] TIMER_IDLE = 32'hFFFF_FFFF;

   logic [31:0] tid;
   logic [31:0] tcfg;
   logic [31:0] tcfg_new;
   logic [31:0] timer_load;
   logic [31:0] timer_reload;
   logic        tid_we;
   logic        tcfg_we;

   assign tid_we       = csr_we && (csr_num == TID_ADDR);
   assign tcfg_we      = csr_we && (csr_num == TCFG_ADDR);
   assign tcfg_new     = ((csr_wmask & csr_wvalue) | (~csr_wmask & tcfg)) & TCFG_MASK;
   assign timer_load   = tcfg_new & ~32'h3;
   assign timer_reload = tcfg & ~32'h3;

   always_ff @(posedge clock) begin
      if (reset) begin
         tid        <= TID_RESET;
         tcfg       <= 32'h0;
         timer_cnt  <= TIMER_IDLE;
         stable_cnt <= 64'h0;
      end else begin
         stable_cnt <= stable_cnt + 64'd1;
         if (tid_we)
            tid <= (csr_wmask & csr_wvalue) | (~csr_wmask & tid);
         if (tcfg_we)
            tcfg <= tcfg_new;
         // a TCFG write owns the timer this cycle: load on En=1, freeze on En=0
         if (tcfg_we) begin
            if (tcfg_new[0])
               timer_cnt <= timer_load;
         end else if (tcfg[0] && (timer_cnt != TIMER_IDLE)) begin
            if ((timer_cnt == 32'h0) && tcfg[1])
               timer_cnt <= timer_reload;
            else
               timer_cnt <= timer_cnt - 32'd1;
         end
      end
   end

   assign counter_id = tid;

   always_comb begin
      csr_rvalue = 32'h0;
      csr_rhit   = 1'b0;
      case (csr_rnum)
         TID_ADDR: begin
            csr_rvalue = tid;
            csr_rhit   = 1'b1;
         end
         TCFG_ADDR: begin
            csr_rvalue = tcfg;
            csr_rhit   = 1'b1;
         end
         TVAL_ADDR: begin
            csr_rvalue = timer_cnt & TCFG_MASK;
            csr_rhit   = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_csr_timer.sv
// Randomized and directed bench for csr_timer against a behavioural model.
module tb_csr_timer;
   logic        clock;
   logic        reset;
   logic        csr_we;
   logic [13:0] csr_num;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wvalue;
   logic [13:0] csr_rnum;
   logic [31:0] csr_rvalue;
   logic        csr_rhit;
   logic [31:0] timer_cnt;
   logic [63:0] stable_cnt;
   logic [31:0] counter_id;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   logic [31:0] m_tid;
   logic [31:0] m_tcfg;
   logic [31:0] m_timer;
   logic [63:0] m_stable;

   csr_timer dut (
      .clock      (clock),
      .reset      (reset),
      .csr_we     (csr_we),
      .csr_num    (csr_num),
      .csr_wmask  (csr_wmask),
      .csr_wvalue (csr_wvalue),
      .csr_rnum   (csr_rnum),
      .csr_rvalue (csr_rvalue),
      .csr_rhit   (csr_rhit),
      .timer_cnt  (timer_cnt),
      .stable_cnt (stable_cnt),
      .counter_id (counter_id)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] masked(input logic [31:0] oldv);
      return (csr_wmask & csr_wvalue) | (~csr_wmask & oldv);
   endfunction

   // one clock edge: advance the model from the applied inputs, then compare
   task automatic step();
      logic [31:0] n_tid, n_tcfg, n_timer;
      logic [63:0] n_stable;
      logic [31:0] exp_rd;
      logic        exp_hit;
      n_tid = m_tid; n_tcfg = m_tcfg; n_timer = m_timer; n_stable = m_stable + 64'd1;
      if (reset) begin
         n_tid = 32'h0; n_tcfg = 32'h0; n_timer = 32'hFFFF_FFFF; n_stable = 64'd0;
      end else begin
         if (csr_we && csr_num == 14'h40) n_tid = masked(m_tid);
         if (csr_we && csr_num == 14'h41) begin
            n_tcfg = masked(m_tcfg);
            if (n_tcfg[0]) n_timer = {n_tcfg[31:2], 2'b00};
         end else if (m_tcfg[0] && m_timer != 32'hFFFF_FFFF) begin
            if (m_timer == 0 && m_tcfg[1]) n_timer = {m_tcfg[31:2], 2'b00};
            else n_timer = m_timer - 1;
         end
      end
      @(posedge clock);
      #1;
      m_tid = n_tid; m_tcfg = n_tcfg; m_timer = n_timer; m_stable = n_stable;
      exp_hit = (csr_rnum == 14'h40) || (csr_rnum == 14'h41) || (csr_rnum == 14'h42);
      exp_rd  = (csr_rnum == 14'h40) ? m_tid : (csr_rnum == 14'h41) ? m_tcfg :
                (csr_rnum == 14'h42) ? m_timer : 32'h0;
      chk("timer_cnt", timer_cnt, m_timer);
      chk("stable_cnt", stable_cnt, m_stable);
      chk("counter_id", counter_id, m_tid);
      chk("csr_rvalue", csr_rvalue, exp_rd);
      chk("csr_rhit", csr_rhit, exp_hit);
   endtask

   task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
      csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wvalue = val;
      step();
      csr_we = 1'b0;
   endtask

   initial begin
      logic [13:0] addrs [5];
      m_tid = 'x; m_tcfg = 'x; m_timer = 'x; m_stable = 'x;
      reset = 1'b1; csr_we = 1'b0; csr_num = '0; csr_wmask = '0; csr_wvalue = '0;
      csr_rnum = 14'h42;
      step();
      reset = 1'b0;
      repeat (5) step();
      chk("idle_timer", timer_cnt, 64'hFFFF_FFFF);
      chk("idle_stable", stable_cnt, 64'd5);

      // one-shot: 16 down to 0, one cycle at 0, then park at FFFF_FFFF
      wr(14'h41, 32'hFFFF_FFFF, 32'h11);
      chk("oneshot_load", timer_cnt, 64'd16);
      for (int k = 15; k >= 0; k--) begin
         step();
         chk("oneshot_cnt", timer_cnt, 64'(k));
      end
      repeat (3) begin
         step();
         chk("oneshot_park", timer_cnt, 64'hFFFF_FFFF);
      end

      // periodic: 8..0 repeating, period 9
      csr_rnum = 14'h41;
      wr(14'h41, 32'hFFFF_FFFF, 32'h0B);
      chk("periodic_tcfg", csr_rvalue, 64'h0B);
      for (int i = 1; i < 25; i++) begin
         step();
         chk("periodic_cnt", timer_cnt, 64'(8 - (i % 9)));
      end

      // freeze at 5 by clearing En, then restart with a reload
      wr(14'h41, 32'hFFFF_FFFF, 32'h11);
      repeat (11) step();
      chk("pre_freeze", timer_cnt, 64'd5);
      wr(14'h41, 32'h1, 32'h0);
      repeat (4) step();
      chk("frozen", timer_cnt, 64'd5);
      wr(14'h41, 32'hFFFF_FFFF, 32'h11);
      chk("reload", timer_cnt, 64'd16);

      // TVAL is read-only, TID masked, TICLR ignored
      wr(14'h42, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("tval_ro", timer_cnt, 64'd15);
      csr_rnum = 14'h40;
      wr(14'h40, 32'h0000_FFFF, 32'h1234_5678);
      chk("tid_mask", counter_id, 64'h5678);
      wr(14'h44, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("ticlr_tid", counter_id, 64'h5678);

      // reset mid-count beats a same-cycle TCFG write
      wr(14'h41, 32'hFFFF_FFFF, 32'h11);
      repeat (13) step();
      chk("pre_reset", timer_cnt, 64'd3);
      csr_rnum = 14'h41;
      reset = 1'b1;
      wr(14'h41, 32'hFFFF_FFFF, 32'h11);
      reset = 1'b0;
      chk("rst_timer", timer_cnt, 64'hFFFF_FFFF);
      chk("rst_tcfg", csr_rvalue, 64'h0);
      chk("rst_stable", stable_cnt, 64'd0);

      // randomized traffic
      addrs = '{14'h40, 14'h41, 14'h42, 14'h44, 14'h41};
      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(0, 299) == 0);
         csr_we     = ($urandom_range(0, 9) == 0);
         csr_num    = ($urandom_range(0, 7) == 0) ? 14'($urandom) : addrs[$urandom_range(0, 4)];
         csr_wmask  = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
         csr_wvalue = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3F);
         csr_rnum   = ($urandom_range(0, 5) == 0) ? 14'($urandom) : addrs[$urandom_range(0, 3)];
         step();
      end
      reset = 1'b0; csr_we = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
